instr_encoder_loader: RTL and testbench

//  Inverse of the core's instruction decoder. Accepts semantic instruction requests (op, rd, rs1, rs2, imm) over

---
 rtl/instr_encoder_loader.sv | 154 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes semantic RV32I requests (add/sub/addi/lw/sw/beq/jal) and writes them sequentially into imem.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [2:0]    in_rd,
  input  logic [2:0]    in_rs1,
  input  logic [2:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          full,
  output logic [AW:0]   count,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_FULL} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(IMEM_DEPTH);
`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2,
                                         input logic [31:0] imm);
    logic [4:0] d, s1, s2;
    d  = {2'b00, rd};
    s1 = {2'b00, rs1};
    s2 = {2'b00, rs2};
    case (op)
      3'd0:    encode = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      3'd1:    encode = {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      3'd2:    encode = {imm[11:0], s1, 3'b000, d, 7'b0010011};
      3'd3:    encode = {imm[11:0], s1, 3'b010, d, 7'b0000011};
      3'd4:    encode = {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
      3'd5:    encode = {imm[12], imm[10:5], s2, s1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      3'd6:    encode = {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
      default: encode = 32'h0000_0013;
    endcase
  endfunction

  // Sign-extension test: every bit above the field's sign bit must equal it.
  function automatic logic imm_out_of_range(input logic [2:0] op, input logic [31:0] imm);
    case (op)
      3'd2, 3'd3, 3'd4: imm_out_of_range = !((&imm[31:11]) || !(|imm[31:11]));
      3'd5:             imm_out_of_range = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'd6:             imm_out_of_range = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:          imm_out_of_range = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_FULL: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (start) begin
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (in_valid) begin
          wdata_d = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
          err_d   = err_q | (in_op == 3'd7) | (RANGE_CHECK & imm_out_of_range(in_op, in_imm));
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          count_d = count_q + 1'b1;
          // The address stops on the last slot so it never wraps inside a session.
          if (count_d == DEPTH_C) begin
            state_d = S_FULL;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_ACCEPT);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d == S_ACCEPT) || (state_d == S_WRITE);
    full_d     = (state_d == S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign full      = full_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed + random bench for instr_encoder_loader (IMEM_DEPTH=4) against an arithmetic encoding model.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, mem_ready;
  logic [2:0]    in_op, in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          in_ready, mem_we, busy, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  int exp_addr, exp_count;
  logic exp_err;

  instr_encoder_loader #(.IMEM_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .full(full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder: each field shifted into its bit position and OR'ed in.
  function automatic logic [31:0] ref_word(input logic [31:0] op, input logic [31:0] rd,
                                           input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [31:0] u);
    case (op)
      0: return 32'h33 | (rd << 7) | (rs1 << 15) | (rs2 << 20);
      1: return 32'h4000_0033 | (rd << 7) | (rs1 << 15) | (rs2 << 20);
      2: return 32'h13 | (rd << 7) | (rs1 << 15) | ((u & 32'hFFF) << 20);
      3: return 32'h03 | (32'd2 << 12) | (rd << 7) | (rs1 << 15) | ((u & 32'hFFF) << 20);
      4: return 32'h23 | (32'd2 << 12) | (rs1 << 15) | (rs2 << 20) | ((u & 31) << 7)
                | (((u >> 5) & 127) << 25);
      5: return 32'h63 | (rs1 << 15) | (rs2 << 20) | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8)
                | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
      6: return 32'h6F | (rd << 7) | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
                | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
      default: return 32'h13;
    endcase
  endfunction

  function automatic logic ref_err(input logic [31:0] op, input logic [31:0] u);
    int s;
    s = signed'(u);
    if (op == 7) return 1'b1;
`ifdef ENCODER_RANGE_CHECK_EN
    if (op >= 2 && op <= 4) return (s < -2048 || s > 2047);
    if (op == 5) return (s < -4096 || s > 4095 || u[0]);
    if (op == 6) return (s < -1048576 || s > 1048575 || u[0]);
`endif
    return 1'b0;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_count", count, 0);
    chk("start_addr", mem_addr, 0);
    chk("start_busy", busy, 1);
    chk("start_full", full, 0);
    chk("start_err", err, 0);
  endtask

  // One request: accept, hold mem_ready low for 'stall' cycles, then complete the write.
  task automatic do_req(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [31:0] imm, input int stall);
    logic [31:0] w;
    w = ref_word(32'(op), 32'(rd), 32'(rs1), 32'(rs2), imm);
    chk("req_in_ready", in_ready, 1);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    exp_err = exp_err | ref_err(32'(op), imm);
    chk("acc_mem_we", mem_we, 1);
    chk("acc_addr", mem_addr, exp_addr);
    chk("acc_wdata", mem_wdata, w);
    chk("acc_in_ready", in_ready, 0);
    chk("acc_err", err, exp_err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_mem_we", mem_we, 1);
      chk("stall_addr", mem_addr, exp_addr);
      chk("stall_wdata", mem_wdata, w);
      chk("stall_in_ready", in_ready, 0);
    end
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    exp_count++;
    if (exp_count < DEPTH) exp_addr++;
    chk("wr_count", count, exp_count);
    chk("wr_mem_we", mem_we, 0);
    chk("wr_full", full, exp_count == DEPTH);
    chk("wr_in_ready", in_ready, exp_count != DEPTH);
    chk("wr_addr", mem_addr, exp_addr);
    $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d imm=%08h -> word=%08h count=%0d err=%0b",
             op, rd, rs1, rs2, imm, mem_wdata, count, err);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // T1..T3 (known encodings) spread across sessions of depth 4
    do_start();
    do_req(3'd2, 3'd1, 3'd2, 3'd0, 32'hFFFF_FFFF, 0);
    chk("t1_word", mem_wdata, 32'hFFF1_0093);
    do_req(3'd1, 3'd3, 3'd1, 3'd2, 32'h0, 0);
    chk("t2_sub", mem_wdata, 32'h4020_81B3);
    do_req(3'd4, 3'd0, 3'd1, 3'd2, 32'd8, 0);
    chk("t2_sw", mem_wdata, 32'h0020_A423);
    do_req(3'd5, 3'd0, 3'd1, 3'd2, 32'hFFFF_FFFC, 0);
    chk("t3_beq", mem_wdata, 32'hFE20_8EE3);

    // T5: full blocks further input
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("full_blocks_in_ready", in_ready, 0);
    chk("full_blocks_mem_we", mem_we, 0);
    chk("full_blocks_count", count, DEPTH);
    chk("full_busy", busy, 0);

    do_start();
    do_req(3'd6, 3'd1, 3'd0, 3'd0, 32'd8, 5);   // T4 stall + jal
    chk("t3_jal", mem_wdata, 32'h0080_00EF);

    // start during WRITE is ignored
    in_op = 3'd0; in_rd = 3'd5; in_rs1 = 3'd6; in_rs2 = 3'd7; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start_in_write_mem_we", mem_we, 1);
    chk("start_in_write_addr", mem_addr, 1);
    mem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    exp_count = 2; exp_addr = 2;
    chk("start_in_write_count", count, 2);

    // T6: illegal op writes NOP and sets sticky err
    do_req(3'd7, 3'd3, 3'd3, 3'd3, 32'h1234, 0);
    chk("t6_nop", mem_wdata, 32'h0000_0013);
    chk("t6_err", err, 1);
    do_req(3'd0, 3'd1, 3'd1, 3'd1, 32'h0, 0);
    chk("t6_err_sticky", err, 1);

    // start + request in ACCEPT: request dropped, session restarts
    do_start();
    do_req(3'd2, 3'd1, 3'd1, 3'd0, 32'd5, 0);
    in_valid = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    chk("restart_mem_we", mem_we, 0);
    chk("restart_count", count, 0);
    chk("restart_addr", mem_addr, 0);
    chk("restart_in_ready", in_ready, 1);

    // range-check boundary (addi 2048); err only when the option is built in
    do_req(3'd2, 3'd1, 3'd1, 3'd0, 32'd2048, 0);
    do_req(3'd2, 3'd1, 3'd1, 3'd0, 32'd2047, 0);

    // reset mid-WRITE drops mem_we asynchronously
    do_start();
    in_op = 3'd2; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_mem_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_we", mem_we, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // random traffic
    do_start();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = ($urandom_range(0, 1) != 0) ? 32'hFFFF_F800 : 32'h0000_07FF;
        2: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = $urandom;
      endcase
      do_req(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), imm,
             int'($urandom_range(0, 2)));
      if (exp_count == DEPTH) do_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
